// File: rtl/pcileech_bar_cpl_pkg.sv
// pcileech_bar_cpl_pkg
//   Shared definitions for the BAR read completion builder:
//   - bit positions and widths of the fields inside the 88-bit reply context
//   - the fixed CplD header constants (3DW header with data, successful completion)
//   - cpl_entry_t, the entry type held in the reply FIFO
//   Optional feature macro used by the top: BAR_CPL_STATS_EN.
package pcileech_bar_cpl_pkg;

    localparam int CTX_REQID_LSB = 0;
    localparam int CTX_REQID_W   = 16;
    localparam int CTX_TAG_LSB   = 16;
    localparam int CTX_TAG_W     = 8;
    localparam int CTX_LADDR_LSB = 24;
    localparam int CTX_LADDR_W   = 7;
    localparam int CTX_TC_LSB    = 31;
    localparam int CTX_TC_W      = 3;
    localparam int CTX_ATTR_LSB  = 34;
    localparam int CTX_ATTR_W    = 2;
    localparam int CTX_BC_LSB    = 36;
    localparam int CTX_BC_W      = 12;
    localparam int CTX_USED_W    = 48;

    localparam logic [2:0] FMT_3DW_DATA = 3'b010;
    localparam logic [4:0] TYPE_CPL     = 5'b01010;
    localparam logic [2:0] CPL_SC       = 3'b000;

    typedef struct packed {
        logic [CTX_USED_W-1:0] ctx;
        logic [31:0]           data;
    } cpl_entry_t;

endpackage

// File: rtl/pcileech_bar_cpl_fifo.sv
// pcileech_bar_cpl_fifo
//   Synchronous FIFO of cpl_entry_t with asynchronous active-high reset.
//   Ports:
//     clk, rst          clock, async active-high reset
//     push, push_data   write request and entry
//     pop               read request (only issued when !empty)
//     pop_data          entry at the head, valid while !empty
//     full, empty       occupancy flags
//     drop              push refused: full with no pop in the same cycle
//   A push into a full FIFO is accepted when a pop happens in the same cycle,
//   since the head slot is freed at the same edge the tail slot is written.
module pcileech_bar_cpl_fifo
    import pcileech_bar_cpl_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  cpl_entry_t push_data,
    input  logic       pop,
    output cpl_entry_t pop_data,
    output logic       full,
    output logic       empty,
    output logic       drop
);

    localparam int AW = $clog2(DEPTH);

    cpl_entry_t  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push_ok;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign push_ok  = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcileech_bar_cpl_builder.sv
// pcileech_bar_cpl_builder
//   Return path of the BAR read interface. Replies from the BAR emulation block
//   are queued in a FIFO (no backpressure towards the BAR side) and each one is
//   turned into a single-beat 128-bit CplD TLP {data, DW2, DW1, DW0}.
//   Ports:
//     clk, rst                    clock, async active-high reset
//     rd_rsp_ctx/data/valid       reply from the BAR block, one per cycle
//     completer_id                bus/dev/fn, sampled when a TLP is loaded
//     tx_data/keep_dw/last/valid  single-beat TLP towards the TX arbiter
//     tx_ready                    beat accepted when tx_valid && tx_ready
//     ovf_sticky                  a reply was dropped since reset
//   Optional (macro BAR_CPL_STATS_EN): cpl_sent_cnt (wrapping), cpl_drop_cnt
//   (saturating).
module pcileech_bar_cpl_builder
    import pcileech_bar_cpl_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [87:0]  rd_rsp_ctx,
    input  logic [31:0]  rd_rsp_data,
    input  logic         rd_rsp_valid,
    input  logic [15:0]  completer_id,
    output logic [127:0] tx_data,
    output logic [3:0]   tx_keep_dw,
    output logic         tx_last,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         ovf_sticky
`ifdef BAR_CPL_STATS_EN
   ,output logic [31:0]  cpl_sent_cnt,
    output logic [15:0]  cpl_drop_cnt
`endif
);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t     state, state_nxt;
    cpl_entry_t push_data;
    cpl_entry_t head;
    logic       fifo_empty;
    logic       fifo_full;
    logic       drop;
    logic       pop;
    logic       unused_ctx_hi;

    assign unused_ctx_hi = ^rd_rsp_ctx[87:CTX_USED_W];

    assign push_data.ctx  = rd_rsp_ctx[CTX_USED_W-1:0];
    assign push_data.data = rd_rsp_data;

    pcileech_bar_cpl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_rsp_valid),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (drop)
    );

    // Header fields of the entry at the FIFO head
    logic [31:0] dw0, dw1, dw2;

    always_comb begin
        dw0 = {FMT_3DW_DATA, TYPE_CPL, 1'b0,
               head.ctx[CTX_TC_LSB +: CTX_TC_W], 4'b0, 1'b0, 1'b0,
               head.ctx[CTX_ATTR_LSB +: CTX_ATTR_W], 2'b0, 10'd1};
        dw1 = {completer_id, CPL_SC, 1'b0, head.ctx[CTX_BC_LSB +: CTX_BC_W]};
        dw2 = {head.ctx[CTX_REQID_LSB +: CTX_REQID_W],
               head.ctx[CTX_TAG_LSB +: CTX_TAG_W], 1'b0,
               head.ctx[CTX_LADDR_LSB +: CTX_LADDR_W]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // tx_valid comes straight from the state register so reset drops it at once
    assign tx_valid   = (state == S_SEND);
    assign tx_last    = tx_valid;
    assign tx_keep_dw = tx_valid ? 4'hF : 4'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data    <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (pop) begin
                tx_data <= {head.data, dw2, dw1, dw0};
            end
            if (drop) begin
                ovf_sticky <= 1'b1;
            end
        end
    end

`ifdef BAR_CPL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpl_sent_cnt <= '0;
            cpl_drop_cnt <= '0;
        end else begin
            if (tx_valid && tx_ready) begin
                cpl_sent_cnt <= cpl_sent_cnt + 32'd1;
            end
            if (drop && (cpl_drop_cnt != 16'hFFFF)) begin
                cpl_drop_cnt <= cpl_drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pcileech_bar_cpl_builder.sv
// tb_pcileech_bar_cpl_builder
//   Scoreboard bench: expected TLPs are queued when replies are driven and
//   compared whenever the DUT presents a beat. Uses FIFO_DEPTH=4 so overflow
//   is reachable with a handful of replies.
module tb_pcileech_bar_cpl_builder;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [87:0]  rd_rsp_ctx = '0;
    logic [31:0]  rd_rsp_data = '0;
    logic         rd_rsp_valid = 1'b0;
    logic [15:0]  completer_id = '0;
    logic [127:0] tx_data;
    logic [3:0]   tx_keep_dw;
    logic         tx_last;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic         ovf_sticky;
`ifdef BAR_CPL_STATS_EN
    logic [31:0]  cpl_sent_cnt;
    logic [15:0]  cpl_drop_cnt;
`endif

    pcileech_bar_cpl_builder #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_rsp_ctx   (rd_rsp_ctx),
        .rd_rsp_data  (rd_rsp_data),
        .rd_rsp_valid (rd_rsp_valid),
        .completer_id (completer_id),
        .tx_data      (tx_data),
        .tx_keep_dw   (tx_keep_dw),
        .tx_last      (tx_last),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .ovf_sticky   (ovf_sticky)
`ifdef BAR_CPL_STATS_EN
       ,.cpl_sent_cnt (cpl_sent_cnt),
        .cpl_drop_cnt (cpl_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int sent     = 0;
    logic [127:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [87:0] mk_ctx(input logic [15:0] req, input logic [7:0] tag,
                                           input logic [6:0] la, input logic [2:0] tc,
                                           input logic [1:0] attr, input logic [11:0] bc);
        logic [39:0] hi;
        hi = {8'hA5, 32'($urandom())};
        return {hi, bc, attr, tc, la, tag, req};
    endfunction

    function automatic logic [127:0] exp_tlp(input logic [87:0] c, input logic [31:0] d,
                                             input logic [15:0] cid);
        logic [31:0] h0, h1, h2;
        h0 = {3'b010, 5'b01010, 1'b0, c[33:31], 4'b0, 2'b00, c[35:34], 2'b0, 10'd1};
        h1 = {cid, 3'b000, 1'b0, c[47:36]};
        h2 = {c[15:0], c[23:16], 1'b0, c[30:24]};
        return {d, h2, h1, h0};
    endfunction

    // Drives one reply for the coming edge; caller is already at a negedge.
    task automatic drive_reply(input logic [87:0] c, input logic [31:0] d, input bit accepted);
        rd_rsp_ctx   = c;
        rd_rsp_data  = d;
        rd_rsp_valid = 1'b1;
        if (accepted) exp_q.push_back(exp_tlp(c, d, completer_id));
    endtask

    task automatic idle_inputs();
        rd_rsp_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_valid) && n < 60) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        sent = 0;
    endtask

    // Monitor: every presented beat must match the scoreboard head.
    always @(negedge clk) begin
        #1;
        if (!rst && tx_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", tx_valid, 1'b0);
            end else begin
                check("tx_data", tx_data, exp_q[0]);
                check("tx_keep_dw", tx_keep_dw, 4'hF);
                check("tx_last", tx_last, 1'b1);
                if (tx_ready) begin
                    void'(exp_q.pop_front());
                    sent++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [87:0] c;
        logic [31:0] d;

        // Reset values
        #1;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_last", tx_last, 1'b0);
        check("rst_tx_keep", tx_keep_dw, 4'h0);
        check("rst_tx_data", tx_data, 128'h0);
        check("rst_ovf", ovf_sticky, 1'b0);
`ifdef BAR_CPL_STATS_EN
        check("rst_sent_cnt", cpl_sent_cnt, 32'd0);
        check("rst_drop_cnt", cpl_drop_cnt, 16'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: single read, literal header values, N+1 latency
        @(negedge clk);
        completer_id = 16'h0300;
        tx_ready     = 1'b1;
        rd_rsp_ctx   = mk_ctx(16'h0100, 8'h2A, 7'h04, 3'd0, 2'b00, 12'd4);
        rd_rsp_data  = 32'h761b0000;
        rd_rsp_valid = 1'b1;
        exp_q.push_back({32'h761b0000, 32'h01002A04, 32'h03000004, 32'h4A000001});
        @(negedge clk);
        idle_inputs();
        #2 check("t1_latency_n", tx_valid, 1'b0);
        @(negedge clk);
        #2 check("t1_latency_n1", tx_valid, 1'b1);
        wait_drain();

        // 2: burst of 5 while stalled, then back-to-back drain
        completer_id = 16'hABCD;
        @(negedge clk);
        tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            d = $urandom();
            drive_reply(mk_ctx(16'h0200 + 16'(i), 8'(i), 7'(i * 4), 3'(i), 2'(i), 12'(i * 8)), d, 1'b1);
            @(negedge clk);
        end
        idle_inputs();
        repeat (10) @(negedge clk);
        #2 check("t2_ovf", ovf_sticky, 1'b0);
        @(negedge clk);
        tx_ready = 1'b1;
        repeat (5) @(negedge clk);
        #2 check("t2_b2b_drained", exp_q.size(), 0);
        wait_drain();

        // 3: overflow with depth 4: 5 held, 6th dropped
        @(negedge clk);
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_reply(mk_ctx(16'h0300, 8'h40 + 8'(i), 7'h10, 3'd1, 2'b01, 12'd16), 32'hC000_0000 + 32'(i), i < 5);
            @(negedge clk);
            if (i == 4) begin
                #2 check("t3_ovf_before", ovf_sticky, 1'b0);
            end
        end
        idle_inputs();
        #2 check("t3_ovf_after", ovf_sticky, 1'b1);
`ifdef BAR_CPL_STATS_EN
        check("t3_drop_cnt", cpl_drop_cnt, 16'd1);
`endif
        @(negedge clk);
        tx_ready = 1'b1;
        wait_drain();
`ifdef BAR_CPL_STATS_EN
        check("t3_sent_cnt", cpl_sent_cnt, 32'(sent));
`endif

        // 4: push into full FIFO coincident with accepted pop
        pulse_reset();
        #2 check("t4_ovf_cleared", ovf_sticky, 1'b0);
        @(negedge clk);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_reply(mk_ctx(16'h0400, 8'h60 + 8'(i), 7'h20, 3'd0, 2'b00, 12'd4), $urandom(), 1'b1);
            @(negedge clk);
        end
        drive_reply(mk_ctx(16'h0400, 8'h65, 7'h20, 3'd0, 2'b00, 12'd4), 32'h5555_AAAA, 1'b1);
        tx_ready = 1'b1;
        @(negedge clk);
        idle_inputs();
        wait_drain();
        check("t4_no_ovf", ovf_sticky, 1'b0);
`ifdef BAR_CPL_STATS_EN
        check("t4_drop_cnt", cpl_drop_cnt, 16'd0);
        check("t4_sent_cnt", cpl_sent_cnt, 32'(sent));
`endif

        // 5: reset while a beat is presented with 3 entries queued
        @(negedge clk);
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_reply(mk_ctx(16'h0500, 8'h70 + 8'(i), 7'h30, 3'd0, 2'b00, 12'd4), $urandom(), 1'b1);
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
        #2 check("t5_valid_before_rst", tx_valid, 1'b1);
        #1 rst = 1'b1;
        #1 check("t5_valid_async_drop", tx_valid, 1'b0);
        exp_q.delete();
        sent = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tx_ready = 1'b1;
        repeat (10) @(negedge clk);
        #2 check("t5_no_stale", tx_valid, 1'b0);
        check("t5_data_cleared", tx_data, 128'h0);

        // 6: TC/attr placement and byte_count 0 passed through
        completer_id = 16'h0300;
        @(negedge clk);
        c = mk_ctx(16'h0100, 8'h2A, 7'h04, 3'd2, 2'b10, 12'd0);
        rd_rsp_ctx   = c;
        rd_rsp_data  = 32'h1234_5678;
        rd_rsp_valid = 1'b1;
        exp_q.push_back({32'h1234_5678, 32'h01002A04, 32'h03000000, 32'h4A202001});
        @(negedge clk);
        idle_inputs();
        wait_drain();
`ifdef BAR_CPL_STATS_EN
        check("t6_sent_cnt", cpl_sent_cnt, 32'(sent));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
